// File: rtl/mesh_route_decoder.sv
// Route computation stage for one mesh router interface: rewrites the packet's top byte with
// the dimension-ordered output port (or 8'hFF when the destination is unreachable), registered.
module mesh_route_decoder #(
    parameter int unsigned pckg_sz = 40,
    parameter int unsigned id_r    = 0,
    parameter int unsigned id_c    = 0,
    parameter int unsigned rows    = 4,
    parameter int unsigned columns = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [pckg_sz-1:0] Data_out_i_in,
    output logic [pckg_sz-1:0] Data_out_i,
    output logic               route_err
);

    localparam logic [3:0] RowId   = 4'(id_r);
    localparam logic [3:0] ColId   = 4'(id_c);
    localparam logic [3:0] RowLast = 4'(rows + 1);
    localparam logic [3:0] ColLast = 4'(columns + 1);

    localparam logic [1:0] PortNorth = 2'd0;
    localparam logic [1:0] PortSouth = 2'd1;
    localparam logic [1:0] PortEast  = 2'd2;
    localparam logic [1:0] PortWest  = 2'd3;

    logic [3:0]         tr;
    logic [3:0]         tc;
    logic               m;
    logic [1:0]         row_port;
    logic [1:0]         col_port;
    logic [1:0]         port;
    logic               row_edge;
    logic               col_edge;
    logic               err_d;
    logic [pckg_sz-1:0] data_d;

    always_comb begin
        tr       = Data_out_i_in[pckg_sz-9 -: 4];
        tc       = Data_out_i_in[pckg_sz-13 -: 4];
        m        = Data_out_i_in[pckg_sz-17];

        row_port = (tr < RowId) ? PortNorth : PortSouth;
        col_port = (tc > ColId) ? PortEast : PortWest;
        if (m) begin
            port = (tr != RowId) ? row_port : col_port;
        end else begin
            port = (tc != ColId) ? col_port : row_port;
        end

        // Corners of the terminal ring carry no terminal.
        row_edge = (tr == 4'd0) || (tr == RowLast);
        col_edge = (tc == 4'd0) || (tc == ColLast);
        err_d    = ((tr == RowId) && (tc == ColId)) ||
                   (tr > RowLast) || (tc > ColLast) ||
                   (row_edge && col_edge);

        data_d                   = Data_out_i_in;
        data_d[pckg_sz-1 -: 8]   = err_d ? 8'hFF : {6'b0, port};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_out_i <= '0;
            route_err  <= 1'b0;
        end else begin
            Data_out_i <= data_d;
            route_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_mesh_route_decoder.sv
// Scoreboard bench for mesh_route_decoder: a centre router (2,2) and a border router (1,4)
// see the same packet stream; expectations are queued at drive time and popped one cycle later.
module tb_mesh_route_decoder;

    localparam int unsigned PSz = 40;

    logic           clk;
    logic           rst;
    logic [PSz-1:0] din;
    logic [PSz-1:0] dout_a;
    logic [PSz-1:0] dout_b;
    logic           err_a;
    logic           err_b;
    logic           drv_vld;

    int n_vec;
    int n_err;

    logic [PSz:0] exp_a_q[$];
    logic [PSz:0] exp_b_q[$];

    mesh_route_decoder #(
        .pckg_sz(PSz), .id_r(2), .id_c(2), .rows(4), .columns(4)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .Data_out_i_in(din),
        .Data_out_i   (dout_a),
        .route_err    (err_a)
    );

    mesh_route_decoder #(
        .pckg_sz(PSz), .id_r(1), .id_c(4), .rows(4), .columns(4)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .Data_out_i_in(din),
        .Data_out_i   (dout_b),
        .route_err    (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {route_err, routed packet}.
    function automatic logic [PSz:0] route_model(input logic [PSz-1:0] p, input int ir,
                                                 input int ic, input int nr, input int nc);
        int   tr;
        int   tc;
        int   hop;
        bit   err;
        bit   corner;
        logic [7:0] top;
        tr     = int'(p[31:28]);
        tc     = int'(p[27:24]);
        corner = (tr == 0 || tr == nr + 1) && (tc == 0 || tc == nc + 1);
        err    = (tr == ir && tc == ic) || (tr > nr + 1) || (tc > nc + 1) || corner;
        if (p[23]) begin
            if (tr < ir)      hop = 0;
            else if (tr > ir) hop = 1;
            else if (tc > ic) hop = 2;
            else              hop = 3;
        end else begin
            if (tc > ic)      hop = 2;
            else if (tc < ic) hop = 3;
            else if (tr < ir) hop = 0;
            else              hop = 1;
        end
        top = err ? 8'hFF : 8'(hop);
        return {err, top, p[31:0]};
    endfunction

    function automatic logic [PSz-1:0] mk(input int tr, input int tc, input bit m);
        return {8'hA5, 4'(tr), 4'(tc), m, 23'h5A5A5};
    endfunction

    task automatic send(input logic [PSz-1:0] p);
        @(negedge clk);
        din     = p;
        drv_vld = 1'b1;
        exp_a_q.push_back(route_model(p, 2, 2, 4, 4));
        exp_b_q.push_back(route_model(p, 1, 4, 4, 4));
    endtask

    task automatic idle();
        @(negedge clk);
        drv_vld = 1'b0;
    endtask

    // Output of a packet driven before this edge is compared just after it.
    always @(posedge clk) begin
        if (drv_vld && rst) begin
            #1;
            if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
                check_val("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                logic [PSz:0] ea;
                logic [PSz:0] eb;
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                check_val("a_data", 64'(dout_a), 64'(ea[PSz-1:0]));
                check_val("a_err",  64'(err_a),  64'(ea[PSz]));
                check_val("b_data", 64'(dout_b), 64'(eb[PSz-1:0]));
                check_val("b_err",  64'(err_b),  64'(eb[PSz]));
            end
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        din     = '0;
        drv_vld = 1'b0;

        #2;
        check_val("reset_data", 64'(dout_a), 64'd0);
        check_val("reset_err",  64'(err_a),  64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases, back to back.
        send(mk(0, 2, 1'b1));   // centre: north
        send(mk(2, 5, 1'b1));   // centre: east
        send(mk(2, 0, 1'b0));   // centre: west
        send(mk(5, 0, 1'b1));   // centre: south
        send(mk(5, 0, 1'b0));   // centre: west (mode flips first dimension)
        send(mk(2, 2, 1'b1));   // centre: self -> error
        send(mk(7, 1, 1'b1));   // out of range row
        send(mk(0, 0, 1'b0));   // corner
        send(mk(1, 9, 1'b0));   // out of range column
        send(mk(5, 5, 1'b1));   // corner
        send(mk(1, 5, 1'b1));   // border: east
        send(mk(0, 4, 1'b1));   // border: north
        send(mk(1, 0, 1'b0));   // border: west
        send(mk(1, 4, 1'b0));   // border: self -> error
        idle();
        idle();

        for (int i = 0; i < 40; i++) begin
            logic [PSz-1:0] p;
            p = {8'($urandom), 32'($urandom)};
            if (i % 4 != 0) begin
                p[31:28] = 4'($urandom_range(0, 5));
                p[27:24] = 4'($urandom_range(0, 5));
            end
            send(p);
            if (i % 7 == 3) idle();
        end
        idle();

        // Asynchronous reset between edges with a packet present.
        send(mk(0, 2, 1'b1));
        @(posedge clk);
        #3;
        rst     = 1'b0;
        drv_vld = 1'b0;
        #1;
        check_val("async_rst_data_a", 64'(dout_a), 64'd0);
        check_val("async_rst_err_a",  64'(err_a),  64'd0);
        check_val("async_rst_data_b", 64'(dout_b), 64'd0);
        @(posedge clk);
        #1;
        check_val("hold_rst_data", 64'(dout_a), 64'd0);
        check_val("hold_rst_err",  64'(err_a),  64'd0);
        send(mk(5, 0, 1'b1));
        #2;
        rst = 1'b1;
        send(mk(7, 1, 1'b0));
        idle();
        idle();

        @(posedge clk);
        #2;
        check_val("drain_a", 64'(exp_a_q.size()), 64'd0);
        check_val("drain_b", 64'(exp_b_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mesh_route_decoder.md
Name: mesh_route_decoder

Overview:
- Per-router route computation stage for the 2-D mesh NoC.
- Takes a packet arriving at one of the router's four interfaces and rewrites its top byte with the output port it must leave on. Uses dimension-ordered routing, row-first or column-first, selected per packet.
- One instance sits inside each router interface, between the input FIFO head and the router arbiter.
- Output is registered: one-cycle latency.

Parameters:
- pckg_sz, 40: packet width in bits; must be ≥ 24.
- id_r, 0: row coordinate of the owning router.
- id_c, 0: column coordinate of the owning router.
- rows, 4: number of router rows. Routers occupy rows 1..rows; terminals sit at rows 0 and rows+1.
- columns, 4: number of router columns. Routers occupy columns 1..columns; terminals sit at columns 0 and columns+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- Data_out_i_in  input  pckg_sz  incoming packet.
- Data_out_i  output  pckg_sz  packet with next-hop field rewritten.
- route_err  output  1  registered flag: destination invalid for this router.

Behaviour:
- Packet fields of Data_out_i_in:
  - [pckg_sz-1:pckg_sz-8]: next-hop field. Ignored on input, rewritten on output.
  - [pckg_sz-9:pckg_sz-12]: target row tr.
  - [pckg_sz-13:pckg_sz-16]: target column tc.
  - [pckg_sz-17]: mode m (1 = row-first, 0 = column-first).
  - [pckg_sz-18:0]: payload.
- Port encoding: 0 = north (row−1), 1 = south (row+1), 2 = east (col+1), 3 = west (col−1).
- Row step: tr<id_r → 0; tr>id_r → 1.
- Column step: tc>id_c → 2; tc<id_c → 3.
- m=1 (row-first): take the row step if tr≠id_r, else the column step.
- m=0 (column-first): take the column step if tc≠id_c, else the row step.
- Error condition, all comparisons unsigned 4-bit:
  - (tr==id_r and tc==id_c), or
  - tr>rows+1, or
  - tc>columns+1, or
  - (tr∈{0,rows+1} and tc∈{0,columns+1}), i.e. a corner, which has no terminal.
- On error: next-hop field = 8'hFF, so no interface id matches and the packet is dropped downstream; route_err=1.
- Otherwise: next-hop field = {6'b0, port}; route_err=0.
- All bits below pckg_sz-8 pass through unchanged, including tr, tc and m.
- Register and reset:
  - Data_out_i and route_err are registered on the rising edge of clk, from the current Data_out_i_in.
  - Latency is exactly 1 cycle; a new packet may be applied every cycle.
- rst low, asynchronously and at any time (including mid-stream):
  - Data_out_i = 0 and route_err = 0 immediately.
  - Both outputs hold while rst is low.
  - The first valid output appears on the first rising edge after rst deasserts.
- Input X or garbage is not filtered: the block decodes whatever is present, with no valid qualifier. The downstream pending flag qualifies the data.
- Pure function of the current input: no internal state beyond the output register.

Test Plan (pckg_sz=40, id_r=2, id_c=2, rows=4, columns=4; tr=[31:28], tc=[27:24], m=[23], payload 23'h5A5A5):
- tr=0, tc=2, m=1 → next cycle Data_out_i[39:32]=8'h00 (north), low 32 bits unchanged, route_err=0.
- tr=2, tc=5, m=1 → [39:32]=8'h02 (east). tr=2, tc=0, m=0 → 8'h03 (west).
- tr=5, tc=0, m=1 → 8'h01 (south). Same packet with m=0 → 8'h03 (west): mode changes the first dimension.
- Error cases: tr=2, tc=2 → [39:32]=8'hFF, route_err=1. tr=7, tc=1 → 8'hFF, route_err=1. tr=0, tc=0 → 8'hFF, route_err=1. Back-to-back valid packets on consecutive cycles each appear exactly 1 cycle later.
- Reset: drive rst low asynchronously between edges while a packet is present → Data_out_i=0 and route_err=0 without waiting for a clock. Release rst → first edge after release outputs the routed packet.
- Corner-origin instance (id_r=1, id_c=4): tr=1, tc=5, m=1 → 8'h02. tr=0, tc=4 → 8'h00. tr=1, tc=0 → 8'h03.
